// File: rtl/cache_perf_monitor_pkg.sv
// Shared encodings and defaults for the cache performance monitor.
// Also used by the L1/L2 controllers and the bench.
package cache_perf_monitor_pkg;

  localparam int unsigned DEF_NUM_CH = 2;
  localparam int unsigned DEF_CNT_W  = 32;
  localparam int unsigned DEF_WIN_W  = 16;
  localparam int unsigned NUM_KINDS  = 4;

  typedef enum logic [1:0] {
    RD_HIT  = 2'd0,
    RD_MISS = 2'd1,
    WR_HIT  = 2'd2,
    WR_MISS = 2'd3
  } evKind_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int unsigned chWidth(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter slot for an access: writes in the upper half, misses in the odd slots.
  function automatic evKind_e kindOf(logic we, logic hit);
    return evKind_e'({we, ~hit});
  endfunction

endpackage

// File: rtl/cache_perf_monitor_if.sv
// Event, control and snapshot-readout bundle between a cache level and its perf monitor.
interface cache_perf_monitor_if
  import cache_perf_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned WIN_W  = DEF_WIN_W
);
  localparam int unsigned CH_W = chWidth(NUM_CH);

  logic              en;
  logic              mode;
  logic [WIN_W-1:0]  win_len;
  logic              clr;
  logic [NUM_CH-1:0] ev_valid;
  logic [NUM_CH-1:0] ev_hit;
  logic [NUM_CH-1:0] ev_we;
  logic              snap_req;
  logic              snap_valid;
  logic              snap_ack;
  logic              overrun;
  logic [NUM_CH-1:0] sat;
  logic [CH_W-1:0]   rd_ch;
  logic [1:0]        rd_kind;
  logic [CNT_W-1:0]  rd_data;

  modport master (
    output en, mode, win_len, clr, ev_valid, ev_hit, ev_we,
           snap_req, snap_ack, rd_ch, rd_kind,
    input  snap_valid, overrun, sat, rd_data
  );

  modport slave (
    input  en, mode, win_len, clr, ev_valid, ev_hit, ev_we,
           snap_req, snap_ack, rd_ch, rd_kind,
    output snap_valid, overrun, sat, rd_data
  );

endinterface

// File: rtl/cache_perf_monitor_perf_sat_counter.sv
// Saturating event counter with clear and capture-time reload to zero.
module perf_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             loadZero,
  output logic [CNT_W-1:0] value,
  output logic             satHit_c
);
  localparam logic [CNT_W-1:0] MAX = '1;

  // Flags the increment that lands exactly on all-ones.
  assign satHit_c = inc & ~clr & ~loadZero & (value == (MAX - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      value <= '0;
    end else if (loadZero) begin
      value <= CNT_W'(inc);
    end else if (inc && (value != MAX)) begin
      value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_perf_monitor.sv
// Per-channel read/write hit/miss counters with cumulative or windowed capture
// into a handshaked snapshot bank and a registered readout mux.
module cache_perf_monitor
  import cache_perf_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned WIN_W  = DEF_WIN_W
) (
  input logic clk,
  input logic rst_n,
  cache_perf_monitor_if.slave bus
);
  localparam int unsigned CH_W    = chWidth(NUM_CH);
  localparam int unsigned IDX_W   = CH_W + 2;
  localparam int unsigned NUM_CNT = NUM_CH * NUM_KINDS;

  state_e             state;
  state_e             nextState;
  logic               startRun_c;
  logic               inRun_c;
  logic               modeQ;
  logic [WIN_W-1:0]   winLenQ;
  logic [WIN_W-1:0]   winCnt;
  logic [WIN_W-1:0]   winLoad_c;
  logic               winExpire_c;
  logic               capture_c;
  logic [CNT_W-1:0]   live [NUM_CNT];
  logic [CNT_W-1:0]   snap [NUM_CNT];
  logic [NUM_CNT-1:0] satHit_c;
  logic [NUM_CH-1:0]  satAny_c;
  logic [NUM_CH-1:0]  satQ;
  logic               snapValidQ;
  logic               overrunQ;
  logic [IDX_W-1:0]   rdIdx_c;
  logic [CNT_W-1:0]   rdMux_c;
  logic [CNT_W-1:0]   rdDataQ;

  // State register; clr freezes the state for that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (!bus.clr) begin
      case (state)
        IDLE:    if (bus.en)  nextState = RUN;
        RUN:     if (!bus.en) nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    startRun_c = 1'b0;
    inRun_c    = 1'b0;
    case (state)
      IDLE:    startRun_c = bus.en & ~bus.clr;
      RUN:     inRun_c    = 1'b1;
      default: ;
    endcase
  end

  // Mode and window length latch on entry to RUN; a zero length acts as one.
  assign winLoad_c   = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
  assign winExpire_c = inRun_c & modeQ & (winCnt == WIN_W'(1));
  assign capture_c   = ~bus.clr & (modeQ ? winExpire_c : bus.snap_req);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      modeQ   <= 1'b0;
      winLenQ <= '0;
      winCnt  <= '0;
    end else if (startRun_c) begin
      modeQ   <= bus.mode;
      winLenQ <= winLoad_c;
      winCnt  <= winLoad_c;
    end else if (bus.clr) begin
      winCnt  <= winLenQ;
    end else if (inRun_c && modeQ) begin
      winCnt  <= winExpire_c ? winLenQ : winCnt - WIN_W'(1);
    end
  end

  // Live bank: slot ch*4 + kind; windowed captures restart the count from this cycle's event.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    for (genvar k = 0; k < NUM_KINDS; k++) begin : g_kind
      localparam int unsigned IDX = ch * NUM_KINDS + k;
      logic inc_c;
      assign inc_c = inRun_c & bus.ev_valid[ch] &
                     (kindOf(bus.ev_we[ch], bus.ev_hit[ch]) == evKind_e'(2'(k)));
      perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc_c),
        .clr      (bus.clr),
        .loadZero (capture_c & modeQ),
        .value    (live[IDX]),
        .satHit_c (satHit_c[IDX])
      );
    end
    assign satAny_c[ch] = |satHit_c[ch*NUM_KINDS +: NUM_KINDS];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      for (int i = 0; i < NUM_CNT; i++) snap[i] <= '0;
    end else if (capture_c) begin
      for (int i = 0; i < NUM_CNT; i++) snap[i] <= live[i];
    end
  end

  // Out-of-range channels fall through to zero.
  assign rdIdx_c = {bus.rd_ch, bus.rd_kind};
  always_comb begin
    rdMux_c = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rdIdx_c == IDX_W'(i)) rdMux_c = snap[i];
    end
  end

  // Status and readout; an ack in the capture cycle cancels the overrun.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      snapValidQ <= 1'b0;
      overrunQ   <= 1'b0;
      satQ       <= '0;
      rdDataQ    <= '0;
    end else begin
      satQ    <= satQ | satAny_c;
      rdDataQ <= rdMux_c;
      if (capture_c)         snapValidQ <= 1'b1;
      else if (bus.snap_ack) snapValidQ <= 1'b0;
      if (capture_c && snapValidQ && !bus.snap_ack) overrunQ <= 1'b1;
    end
  end

  assign bus.snap_valid = snapValidQ;
  assign bus.overrun    = overrunQ;
  assign bus.sat        = satQ;
  assign bus.rd_data    = rdDataQ;

endmodule

// File: tb/tb_cache_perf_monitor.sv
// Scoreboard bench for cache_perf_monitor: directed scenarios followed by random traffic,
// checked against an array-based reference of the counting and capture rules.
module tb_cache_perf_monitor;
  import cache_perf_monitor_pkg::*;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned WIN_W  = 4;
  localparam int unsigned CH_W   = chWidth(NUM_CH);
  localparam int          MAXV   = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cache_perf_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

  cache_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic              sv;
    logic              ov;
    logic [NUM_CH-1:0] sat;
    logic [CNT_W-1:0]  rd;
  } exp_t;

  exp_t sbQ [$];
  int   nCmp = 0;
  int   nErr = 0;

  // Reference state
  bit                mRun;
  bit                mMode;
  bit                mSv;
  bit                mOv;
  int                mWinLen = 1;
  int                mRunEdges;
  int                mLive [NUM_CH][4];
  int                mSnap [NUM_CH][4];
  logic [NUM_CH-1:0] mSat;
  int                mRd;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  task automatic clearBanks();
    foreach (mLive[c, k]) begin
      mLive[c][k] = 0;
      mSnap[c][k] = 0;
    end
  endtask

  // Advances the reference by one clock edge using the inputs currently driven.
  task automatic modelStep();
    bit   cap;
    int   newRd;
    int   k;
    exp_t e;
    if (!rst_n) begin
      mRun = 0; mMode = 0; mSv = 0; mOv = 0; mSat = '0; mRd = 0;
      clearBanks();
    end else if (bus.clr) begin
      mSv = 0; mOv = 0; mSat = '0; mRd = 0; mRunEdges = 0;
      clearBanks();
    end else begin
      newRd = 0;
      if (int'(bus.rd_ch) < NUM_CH) newRd = mSnap[bus.rd_ch][bus.rd_kind];
      cap = 0;
      if (mRun) begin
        mRunEdges++;
        if (mMode && (mRunEdges % mWinLen == 0)) cap = 1;
      end
      if (!mMode && bus.snap_req) cap = 1;
      if (cap) begin
        if (mSv && !bus.snap_ack) mOv = 1;
        mSv   = 1;
        mSnap = mLive;
        if (mMode) foreach (mLive[c, j]) mLive[c][j] = 0;
      end else if (bus.snap_ack) begin
        mSv = 0;
      end
      if (mRun) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (bus.ev_valid[c]) begin
            k = (bus.ev_we[c] ? 2 : 0) + (bus.ev_hit[c] ? 0 : 1);
            if (mLive[c][k] < MAXV) begin
              mLive[c][k]++;
              if (mLive[c][k] == MAXV) mSat[c] = 1'b1;
            end
          end
        end
      end
      if (!mRun && bus.en) begin
        mRun      = 1;
        mMode     = bus.mode;
        mWinLen   = (bus.win_len == '0) ? 1 : int'(bus.win_len);
        mRunEdges = 0;
      end else if (mRun && !bus.en) begin
        mRun = 0;
      end
      mRd = newRd;
    end
    e.sv  = mSv;
    e.ov  = mOv;
    e.sat = mSat;
    e.rd  = CNT_W'(mRd);
    sbQ.push_back(e);
  endtask

  task automatic tick();
    modelStep();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    bus.en = 1'b0; bus.mode = 1'b0; bus.win_len = '0; bus.clr = 1'b0;
    bus.ev_valid = '0; bus.ev_hit = '0; bus.ev_we = '0;
    bus.snap_req = 1'b0; bus.snap_ack = 1'b0; bus.rd_ch = '0; bus.rd_kind = '0;
  endtask

  task automatic setEv(int ch, bit v, bit h, bit w);
    bus.ev_valid = '0; bus.ev_hit = '0; bus.ev_we = '0;
    bus.ev_valid[ch] = v; bus.ev_hit[ch] = h; bus.ev_we[ch] = w;
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        chk("sb_snap_valid", 32'(bus.snap_valid), 32'(e.sv));
        chk("sb_overrun",    32'(bus.overrun),    32'(e.ov));
        chk("sb_sat",        32'(bus.sat),        32'(e.sat));
        chk("sb_rd_data",    32'(bus.rd_data),    32'(e.rd));
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0;
    idleInputs();
    tick(); tick();
    chk("reset_snap_valid", 32'(bus.snap_valid), 32'd0);
    chk("reset_rd_data",    32'(bus.rd_data),    32'd0);
    rst_n = 1'b1;
    tick();

    // Cumulative: five read hits and three write misses on ch0, then a snapshot.
    bus.en = 1'b1; bus.mode = 1'b0;
    tick();
    repeat (5) begin setEv(0, 1'b1, 1'b1, 1'b0); tick(); end
    repeat (3) begin setEv(0, 1'b1, 1'b0, 1'b1); tick(); end
    setEv(0, 1'b0, 1'b0, 1'b0);
    bus.snap_req = 1'b1;
    tick();
    bus.snap_req = 1'b0; bus.rd_ch = '0; bus.rd_kind = 2'd0;
    tick();
    chk("cum_rd_hit",     32'(bus.rd_data),    32'd5);
    chk("cum_snap_valid", 32'(bus.snap_valid), 32'd1);
    bus.rd_kind = 2'd3;
    tick();
    chk("cum_wr_miss", 32'(bus.rd_data), 32'd3);
    bus.rd_kind = 2'd1;
    tick();
    chk("cum_rd_miss", 32'(bus.rd_data), 32'd0);
    bus.rd_ch = CH_W'(NUM_CH);
    tick();
    chk("rd_ch_out_of_range", 32'(bus.rd_data), 32'd0);

    // Windowed, length 4, ch1 read miss every cycle, never acked.
    bus.en = 1'b0;
    tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0; bus.mode = 1'b1; bus.win_len = WIN_W'(4); bus.en = 1'b1;
    bus.rd_ch = CH_W'(1); bus.rd_kind = 2'd1;
    setEv(1, 1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    chk("win_full_count", 32'(bus.rd_data), 32'd4);
    chk("win_overrun",    32'(bus.overrun), 32'd1);

    // clr on the edge where a window capture would fire.
    tick(); tick();
    bus.clr = 1'b1; bus.snap_req = 1'b1;
    tick();
    chk("clr_snap_valid", 32'(bus.snap_valid), 32'd0);
    chk("clr_overrun",    32'(bus.overrun),    32'd0);
    chk("clr_sat",        32'(bus.sat),        32'd0);
    chk("clr_rd_data",    32'(bus.rd_data),    32'd0);
    bus.clr = 1'b0; bus.snap_req = 1'b0;

    // Second capture after clr lands together with an ack.
    repeat (7) tick();
    bus.snap_ack = 1'b1;
    tick();
    chk("cap_ack_snap_valid", 32'(bus.snap_valid), 32'd1);
    chk("cap_ack_overrun",    32'(bus.overrun),    32'd0);
    bus.snap_ack = 1'b0;
    tick();
    chk("cap_pre_event", 32'(bus.rd_data), 32'd4);

    // Saturation: forty ch0 write hits into a 5-bit counter.
    setEv(0, 1'b0, 1'b0, 1'b0);
    bus.en = 1'b0;
    tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0; bus.mode = 1'b0; bus.en = 1'b1;
    tick();
    repeat (40) begin setEv(0, 1'b1, 1'b1, 1'b1); tick(); end
    setEv(0, 1'b0, 1'b0, 1'b0);
    bus.snap_req = 1'b1;
    tick();
    bus.snap_req = 1'b0; bus.rd_ch = '0; bus.rd_kind = 2'd2;
    tick();
    chk("sat_value", 32'(bus.rd_data), 32'(MAXV));
    chk("sat_flag",  32'(bus.sat),     32'd1);

    // Reset in the middle of a window.
    bus.en = 1'b0;
    tick();
    bus.mode = 1'b1; bus.win_len = WIN_W'(5); bus.en = 1'b1;
    tick();
    repeat (3) begin setEv(2, 1'b1, 1'b1, 1'b0); tick(); end
    rst_n = 1'b0;
    tick();
    chk("rst_snap_valid", 32'(bus.snap_valid), 32'd0);
    chk("rst_overrun",    32'(bus.overrun),    32'd0);
    chk("rst_sat",        32'(bus.sat),        32'd0);
    chk("rst_rd_data",    32'(bus.rd_data),    32'd0);
    rst_n = 1'b1;

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(59) == 0) bus.en = ~bus.en;
      bus.mode     = 1'($urandom_range(1));
      bus.win_len  = WIN_W'($urandom_range(6));
      bus.clr      = ($urandom_range(399) == 0);
      rst_n        = ($urandom_range(999) != 0);
      bus.ev_valid = NUM_CH'($urandom);
      bus.ev_hit   = NUM_CH'($urandom);
      bus.ev_we    = NUM_CH'($urandom);
      bus.snap_req = ($urandom_range(7) == 0);
      bus.snap_ack = ($urandom_range(3) == 0);
      bus.rd_ch    = CH_W'($urandom_range(NUM_CH));
      bus.rd_kind  = 2'($urandom);
      tick();
    end

    rst_n = 1'b1;
    idleInputs();
    tick(); tick();
    chk("sb_drain", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
